// File: rtl/nebula_pkg.sv
// Shared types and constants for the nebula mesh and its traffic nodes.
package nebula_pkg;

  localparam int unsigned NEBULA_COORD_W = 4;
  localparam int unsigned NEBULA_SEQ_W   = 16;
  localparam int unsigned NEBULA_DATA_W  = 32;
  localparam int unsigned NEBULA_TS_W    = 16;

  localparam logic [15:0] NEBULA_LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    PACKET_DATA  = 2'd0,
    PACKET_READ  = 2'd1,
    PACKET_WRITE = 2'd2,
    PACKET_RESP  = 2'd3
  } packet_type_t;

  typedef enum logic [1:0] {
    TRAFFIC_UNIFORM   = 2'd0,
    TRAFFIC_NEIGHBOUR = 2'd1,
    TRAFFIC_HOTSPOT   = 2'd2,
    TRAFFIC_TRANSPOSE = 2'd3
  } traffic_pattern_t;

  typedef struct packed {
    logic                      valid;
    packet_type_t              packet_type;
    logic [NEBULA_COORD_W-1:0] src_x;
    logic [NEBULA_COORD_W-1:0] src_y;
    logic [NEBULA_COORD_W-1:0] dest_x;
    logic [NEBULA_COORD_W-1:0] dest_y;
    logic [NEBULA_SEQ_W-1:0]   sequence_num;
    logic [NEBULA_DATA_W-1:0]  data;
  } flit_t;

endpackage

// File: rtl/nebula_lfsr16.sv
// 16-bit Galois LFSR, right-shifting, advancing every cycle outside reset.
module nebula_lfsr16
  import nebula_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next state: shift right, fold taps in when the outgoing bit is set.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ NEBULA_LFSR_TAPS;
    end
  end

  // State register, loads the seed on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/nebula_traffic_node.sv
// Node traffic generator and sink: injects timestamped data flits by pattern
// and rate, and collects delivery/latency statistics on returned flits.
module nebula_traffic_node
  import nebula_pkg::*;
#(
  parameter int unsigned MY_X        = 0,
  parameter int unsigned MY_Y        = 0,
  parameter int unsigned MESH_SIZE_X = 4,
  parameter int unsigned MESH_SIZE_Y = 4,
  parameter int unsigned NUM_PACKETS = 20,
  parameter int unsigned HOTSPOT_X   = 0,
  parameter int unsigned HOTSPOT_Y   = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  pattern,
  input  logic [4:0]  inj_rate,
  output flit_t       req_data,
  output logic        req_valid,
  input  logic        req_ready,
  input  flit_t       resp_data,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic [15:0] pkts_sent,
  output logic [15:0] pkts_recv,
  output logic [15:0] max_latency,
  output logic [31:0] lat_sum,
  output logic        err_misroute
);

  localparam int unsigned CW = NEBULA_COORD_W;
  localparam int unsigned TW = NEBULA_TS_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GEN  = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] MY_X_C  = CW'(MY_X);
  localparam logic [CW-1:0] MY_Y_C  = CW'(MY_Y);
  localparam logic [CW-1:0] HOT_X_C = CW'(HOTSPOT_X);
  localparam logic [CW-1:0] HOT_Y_C = CW'(HOTSPOT_Y);
  localparam logic [CW-1:0] MASK_X  = CW'(MESH_SIZE_X - 1);
  localparam logic [CW-1:0] MASK_Y  = CW'(MESH_SIZE_Y - 1);
  localparam logic [CW-1:0] NN_X    = CW'((MY_X + 1) % MESH_SIZE_X);
  localparam bit            IS_HOT  = (MY_X == HOTSPOT_X) && (MY_Y == HOTSPOT_Y);
  localparam logic [15:0]   NUM_PKT = 16'(NUM_PACKETS);

  logic [15:0] lfsr;

  logic [1:0]       state_q, state_d;
  logic             start_q, start_d;
  logic [1:0]       pattern_in_q, pattern_in_d;
  logic [4:0]       rate_in_q, rate_in_d;
  traffic_pattern_t pattern_q, pattern_d;
  logic [4:0]       rate_q, rate_d;
  logic [TW-1:0]    cyc_q, cyc_d;
  logic             req_valid_q, req_valid_d;
  flit_t            req_data_q, req_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [15:0]      pkts_sent_q, pkts_sent_d;
  logic [15:0]      pkts_recv_q, pkts_recv_d;
  logic [15:0]      max_latency_q, max_latency_d;
  logic [31:0]      lat_sum_q, lat_sum_d;
  logic             err_misroute_q, err_misroute_d;
  logic             resp_ready_q, resp_ready_d;

  logic             accept_start;
  logic [CW-1:0]    dest_x, dest_y;
  logic [TW-1:0]    latency;
  logic             resp_fire;

  nebula_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr)
  );

  // Destination selection for the flit being built this cycle.
  always_comb begin
    dest_x = lfsr[7:4] & MASK_X;
    dest_y = lfsr[11:8] & MASK_Y;
    case (pattern_q)
      TRAFFIC_UNIFORM: ;
      TRAFFIC_NEIGHBOUR: begin
        dest_x = NN_X;
        dest_y = MY_Y_C;
      end
      TRAFFIC_HOTSPOT: begin
        if (!IS_HOT) begin
          dest_x = HOT_X_C;
          dest_y = HOT_Y_C;
        end
      end
      TRAFFIC_TRANSPOSE: begin
        dest_x = MY_Y_C;
        dest_y = MY_X_C;
      end
      default: ;
    endcase
  end

  // Generator FSM next-state, flit build and registered status.
  always_comb begin
    state_d      = state_q;
    start_d      = start;
    pattern_in_d = pattern;
    rate_in_d    = inj_rate;
    pattern_d    = pattern_q;
    rate_d       = rate_q;
    cyc_d        = cyc_q + TW'(1);
    req_valid_d  = req_valid_q;
    req_data_d   = req_data_q;
    pkts_sent_d  = pkts_sent_q;
    accept_start = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_q) begin
          accept_start = 1'b1;
          state_d      = S_GEN;
          pattern_d    = traffic_pattern_t'(pattern_in_q);
          rate_d       = rate_in_q;
          pkts_sent_d  = 16'd0;
        end
      end
      S_GEN: begin
        if ({1'b0, lfsr[3:0]} < rate_q) begin
          req_data_d.valid        = 1'b1;
          req_data_d.packet_type  = PACKET_DATA;
          req_data_d.src_x        = MY_X_C;
          req_data_d.src_y        = MY_Y_C;
          req_data_d.dest_x       = dest_x;
          req_data_d.dest_y       = dest_y;
          req_data_d.sequence_num = pkts_sent_q;
          req_data_d.data         = {16'd0, cyc_q};
          req_valid_d             = 1'b1;
          state_d                 = S_SEND;
        end
      end
      S_SEND: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          pkts_sent_d = pkts_sent_q + 16'd1;
          state_d     = (pkts_sent_d == NUM_PKT) ? S_DONE : S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_GEN) || (state_d == S_SEND);
    done_d = (state_d == S_DONE);
  end

  // Response sink statistics; a run start clears and overrides a handshake.
  always_comb begin
    resp_ready_d   = 1'b1;
    pkts_recv_d    = pkts_recv_q;
    max_latency_d  = max_latency_q;
    lat_sum_d      = lat_sum_q;
    err_misroute_d = err_misroute_q;
    resp_fire      = resp_valid && resp_ready_q;
    latency        = cyc_q - resp_data.data[TW-1:0];
    if (accept_start) begin
      pkts_recv_d    = 16'd0;
      max_latency_d  = 16'd0;
      lat_sum_d      = 32'd0;
      err_misroute_d = 1'b0;
    end else if (resp_fire) begin
      pkts_recv_d = pkts_recv_q + 16'd1;
      lat_sum_d   = lat_sum_q + 32'(latency);
      if (latency > max_latency_q) begin
        max_latency_d = latency;
      end
      if ((resp_data.dest_x != MY_X_C) || (resp_data.dest_y != MY_Y_C)) begin
        err_misroute_d = 1'b1;
      end
    end
  end

  // State and output registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      start_q        <= 1'b0;
      pattern_in_q   <= 2'd0;
      rate_in_q      <= 5'd0;
      pattern_q      <= TRAFFIC_UNIFORM;
      rate_q         <= 5'd0;
      cyc_q          <= '0;
      req_valid_q    <= 1'b0;
      req_data_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pkts_sent_q    <= 16'd0;
      pkts_recv_q    <= 16'd0;
      max_latency_q  <= 16'd0;
      lat_sum_q      <= 32'd0;
      err_misroute_q <= 1'b0;
      resp_ready_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_q        <= start_d;
      pattern_in_q   <= pattern_in_d;
      rate_in_q      <= rate_in_d;
      pattern_q      <= pattern_d;
      rate_q         <= rate_d;
      cyc_q          <= cyc_d;
      req_valid_q    <= req_valid_d;
      req_data_q     <= req_data_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      pkts_sent_q    <= pkts_sent_d;
      pkts_recv_q    <= pkts_recv_d;
      max_latency_q  <= max_latency_d;
      lat_sum_q      <= lat_sum_d;
      err_misroute_q <= err_misroute_d;
      resp_ready_q   <= resp_ready_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{lfsr[15:12], resp_data.valid, resp_data.packet_type,
                         resp_data.src_x, resp_data.src_y, resp_data.sequence_num,
                         resp_data.data[31:16]};

  assign req_data     = req_data_q;
  assign req_valid    = req_valid_q;
  assign resp_ready   = resp_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pkts_sent    = pkts_sent_q;
  assign pkts_recv    = pkts_recv_q;
  assign max_latency  = max_latency_q;
  assign lat_sum      = lat_sum_q;
  assign err_misroute = err_misroute_q;

endmodule

// File: tb/tb_nebula_traffic_node.sv
// Directed bench for nebula_traffic_node: reset, patterns, backpressure,
// latency statistics, misroute flag and zero injection rate.
module tb_nebula_traffic_node;
  import nebula_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [1:0]  pattern;
  logic [4:0]  inj_rate;
  flit_t       req_data;
  logic        req_valid;
  logic        req_ready;
  flit_t       resp_data;
  logic        resp_valid;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic [15:0] pkts_sent;
  logic [15:0] pkts_recv;
  logic [15:0] max_latency;
  logic [31:0] lat_sum;
  logic        err_misroute;

  // Shared stimulus for the transpose and hotspot nodes.
  logic        tp_start, hs_start;
  logic [1:0]  tp_pattern, hs_pattern;
  logic [4:0]  aux_rate;
  logic        aux_ready;
  flit_t       aux_resp;
  logic        aux_resp_valid;
  flit_t       tp_req_data, hs_req_data;
  logic        tp_req_valid, hs_req_valid;
  logic        tp_done, hs_done;
  logic [15:0] tp_pkts_sent, hs_pkts_sent;
  logic        tp_unused_rr, tp_unused_busy, tp_unused_err;
  logic        hs_unused_rr, hs_unused_busy, hs_unused_err;
  logic [15:0] tp_unused_recv, tp_unused_max, hs_unused_recv, hs_unused_max;
  logic [31:0] tp_unused_sum, hs_unused_sum;

  logic [15:0] tb_cyc;
  int n_checks = 0;
  int n_fail   = 0;

  // Reference cycle counter, mirrors the node's free-running timestamp.
  always @(posedge clk) begin
    if (!rst_n) tb_cyc <= 16'd0;
    else        tb_cyc <= tb_cyc + 16'd1;
  end

  nebula_traffic_node #(
    .MY_X(1), .MY_Y(2), .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .NUM_PACKETS(4),
    .HOTSPOT_X(0), .HOTSPOT_Y(0), .LFSR_SEED(16'hACE1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .inj_rate(inj_rate),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .resp_data(resp_data), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .pkts_recv(pkts_recv),
    .max_latency(max_latency), .lat_sum(lat_sum), .err_misroute(err_misroute)
  );

  nebula_traffic_node #(
    .MY_X(3), .MY_Y(1), .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .NUM_PACKETS(3),
    .HOTSPOT_X(0), .HOTSPOT_Y(0), .LFSR_SEED(16'h1234)
  ) u_tp (
    .clk(clk), .rst_n(rst_n), .start(tp_start), .pattern(tp_pattern), .inj_rate(aux_rate),
    .req_data(tp_req_data), .req_valid(tp_req_valid), .req_ready(aux_ready),
    .resp_data(aux_resp), .resp_valid(aux_resp_valid), .resp_ready(tp_unused_rr),
    .busy(tp_unused_busy), .done(tp_done), .pkts_sent(tp_pkts_sent), .pkts_recv(tp_unused_recv),
    .max_latency(tp_unused_max), .lat_sum(tp_unused_sum), .err_misroute(tp_unused_err)
  );

  nebula_traffic_node #(
    .MY_X(2), .MY_Y(2), .MESH_SIZE_X(4), .MESH_SIZE_Y(4), .NUM_PACKETS(3),
    .HOTSPOT_X(0), .HOTSPOT_Y(0), .LFSR_SEED(16'h5A5A)
  ) u_hs (
    .clk(clk), .rst_n(rst_n), .start(hs_start), .pattern(hs_pattern), .inj_rate(aux_rate),
    .req_data(hs_req_data), .req_valid(hs_req_valid), .req_ready(aux_ready),
    .resp_data(aux_resp), .resp_valid(aux_resp_valid), .resp_ready(hs_unused_rr),
    .busy(hs_unused_busy), .done(hs_done), .pkts_sent(hs_pkts_sent), .pkts_recv(hs_unused_recv),
    .max_latency(hs_unused_max), .lat_sum(hs_unused_sum), .err_misroute(hs_unused_err)
  );

  function automatic flit_t mk_req(input logic [3:0] sx, input logic [3:0] sy,
                                   input logic [3:0] dx, input logic [3:0] dy,
                                   input logic [15:0] seq, input logic [15:0] ts);
    flit_t f;
    f.valid        = 1'b1;
    f.packet_type  = PACKET_DATA;
    f.src_x        = sx;
    f.src_y        = sy;
    f.dest_x       = dx;
    f.dest_y       = dy;
    f.sequence_num = seq;
    f.data         = {16'd0, ts};
    return f;
  endfunction

  function automatic flit_t mk_resp(input logic [3:0] dx, input logic [3:0] dy,
                                    input logic [15:0] ts);
    flit_t f;
    f              = '0;
    f.valid        = 1'b1;
    f.packet_type  = PACKET_RESP;
    f.src_x        = 4'd3;
    f.src_y        = 4'd0;
    f.dest_x       = dx;
    f.dest_y       = dy;
    f.data         = {16'hA5A5, ts};
    return f;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({req_valid, resp_ready, busy, done, err_misroute} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 00000", {req_valid, resp_ready, busy, done, err_misroute});
    end
    n_checks++;
    if (req_data !== flit_t'('0)) begin
      n_fail++;
      $display("FAIL reset_req_data: got %h want 0", req_data);
    end
    n_checks++;
    if ({pkts_sent, pkts_recv, max_latency, lat_sum} !== 80'd0) begin
      n_fail++;
      $display("FAIL reset_counters: sent %0d recv %0d max %0d sum %0d want all 0",
               pkts_sent, pkts_recv, max_latency, lat_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (resp_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: resp_ready %b busy %b want 1 0", resp_ready, busy);
    end
  endtask

  task automatic test_latency();
    int guard;
    // Timestamp wrap: stamp 0xFFFE received at cyc 2.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (tb_cyc != 16'd2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    resp_data  = mk_resp(4'd1, 4'd2, 16'hFFFE);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_checks++;
    if (pkts_recv !== 16'd1 || max_latency !== 16'd4 || lat_sum !== 32'd4) begin
      n_fail++;
      $display("FAIL latency_wrap: recv %0d max %0d sum %0d want 1 4 4", pkts_recv, max_latency, lat_sum);
    end
    // Two flits, latencies 7 then 3.
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    resp_data  = mk_resp(4'd1, 4'd2, tb_cyc - 16'd7);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_data  = mk_resp(4'd1, 4'd2, tb_cyc - 16'd3);
    @(negedge clk);
    resp_valid = 1'b0;
    n_checks++;
    if (pkts_recv !== 16'd2 || max_latency !== 16'd7 || lat_sum !== 32'd10) begin
      n_fail++;
      $display("FAIL latency_pair: recv %0d max %0d sum %0d want 2 7 10", pkts_recv, max_latency, lat_sum);
    end
    n_checks++;
    if (err_misroute !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_no_misroute: got %b want 0", err_misroute);
    end
  endtask

  task automatic test_misroute();
    resp_data  = mk_resp(4'd3, 4'd3, tb_cyc);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    n_checks++;
    if (err_misroute !== 1'b1) begin
      n_fail++;
      $display("FAIL misroute_set: got %b want 1", err_misroute);
    end
    resp_data  = mk_resp(4'd1, 4'd2, tb_cyc);
    resp_valid = 1'b1;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (err_misroute !== 1'b1) begin
      n_fail++;
      $display("FAIL misroute_sticky: got %b want 1", err_misroute);
    end
  endtask

  task automatic test_neighbour();
    int seen;
    logic [15:0] prev;
    pattern   = 2'd1;
    inj_rate  = 5'd16;
    req_ready = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || err_misroute !== 1'b0 || pkts_recv !== 16'd0 || max_latency !== 16'd0) begin
      n_fail++;
      $display("FAIL nn_start_clear: busy %b err %b recv %0d max %0d want 1 0 0 0",
               busy, err_misroute, pkts_recv, max_latency);
    end
    seen = 0;
    prev = 16'd0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) break;
      if (req_valid) begin
        n_checks++;
        if (req_data !== mk_req(4'd1, 4'd2, 4'd2, 4'd2, 16'(seen), tb_cyc - 16'd1)) begin
          n_fail++;
          $display("FAIL nn_flit%0d: got %h want %h", seen, req_data,
                   mk_req(4'd1, 4'd2, 4'd2, 4'd2, 16'(seen), tb_cyc - 16'd1));
        end
        if (seen > 0) begin
          n_checks++;
          if (tb_cyc - prev !== 16'd2) begin
            n_fail++;
            $display("FAIL nn_spacing%0d: got %0d cycles want 2", seen, tb_cyc - prev);
          end
        end
        prev = tb_cyc;
        seen++;
      end
    end
    n_checks++;
    if (seen != 4 || done !== 1'b1 || busy !== 1'b0 || pkts_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL nn_done: flits %0d done %b busy %b sent %0d want 4 1 0 4", seen, done, busy, pkts_sent);
    end
  endtask

  task automatic test_backpressure();
    int guard;
    flit_t exp;
    req_ready = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!req_valid && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    exp = mk_req(4'd1, 4'd2, 4'd2, 4'd2, 16'd0, tb_cyc - 16'd1);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (req_valid !== 1'b1 || req_data !== exp || pkts_sent !== 16'd0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid %b data %h sent %0d want 1 %h 0", i, req_valid, req_data, pkts_sent, exp);
      end
      @(negedge clk);
    end
    req_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (pkts_sent !== 16'd1 || req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: sent %0d valid %b want 1 0", pkts_sent, req_valid);
    end
    guard = 0;
    while (!done && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (done !== 1'b1 || pkts_sent !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_done: done %b sent %0d want 1 4", done, pkts_sent);
    end
  endtask

  task automatic test_zero_rate();
    pattern  = 2'd0;
    inj_rate = 5'd0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (pkts_sent !== 16'd0 || done !== 1'b0 || busy !== 1'b1 || req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_rate: sent %0d done %b busy %b valid %b want 0 0 1 0",
               pkts_sent, done, busy, req_valid);
    end
  endtask

  task automatic test_transpose_hotspot();
    int seen;
    tp_start = 1'b1;
    @(negedge clk);
    tp_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tp_done) break;
      if (tp_req_valid) begin
        n_checks++;
        if (tp_req_data !== mk_req(4'd3, 4'd1, 4'd1, 4'd3, 16'(seen), tb_cyc - 16'd1)) begin
          n_fail++;
          $display("FAIL transpose_flit%0d: got %h want %h", seen, tp_req_data,
                   mk_req(4'd3, 4'd1, 4'd1, 4'd3, 16'(seen), tb_cyc - 16'd1));
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 3 || tp_done !== 1'b1 || tp_pkts_sent !== 16'd3) begin
      n_fail++;
      $display("FAIL transpose_done: flits %0d done %b sent %0d want 3 1 3", seen, tp_done, tp_pkts_sent);
    end
    hs_start = 1'b1;
    @(negedge clk);
    hs_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (hs_done) break;
      if (hs_req_valid) begin
        n_checks++;
        if (hs_req_data.dest_x !== 4'd0 || hs_req_data.dest_y !== 4'd0 ||
            hs_req_data.src_x !== 4'd2 || hs_req_data.src_y !== 4'd2) begin
          n_fail++;
          $display("FAIL hotspot_flit%0d: dest (%0d,%0d) src (%0d,%0d) want (0,0) (2,2)", seen,
                   hs_req_data.dest_x, hs_req_data.dest_y, hs_req_data.src_x, hs_req_data.src_y);
        end
        seen++;
      end
    end
    n_checks++;
    if (seen != 3 || hs_done !== 1'b1 || hs_pkts_sent !== 16'd3) begin
      n_fail++;
      $display("FAIL hotspot_done: flits %0d done %b sent %0d want 3 1 3", seen, hs_done, hs_pkts_sent);
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    pattern        = 2'd0;
    inj_rate       = 5'd0;
    req_ready      = 1'b0;
    resp_data      = '0;
    resp_valid     = 1'b0;
    tp_start       = 1'b0;
    hs_start       = 1'b0;
    tp_pattern     = 2'd3;
    hs_pattern     = 2'd2;
    aux_rate       = 5'd16;
    aux_ready      = 1'b1;
    aux_resp       = '0;
    aux_resp_valid = 1'b0;
    test_reset();
    test_latency();
    test_misroute();
    test_neighbour();
    test_backpressure();
    test_zero_rate();
    test_transpose_hotspot();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/nebula_traffic_node.md
# nebula_traffic_node

Node-side traffic generator and sink attached to one `nebula_router` local port in the mesh. It injects a fixed number of `PACKET_DATA` flits using a selectable traffic pattern and an LFSR-gated injection rate, and stamps each flit with its injection cycle. It consumes response flits and accumulates delivery and latency statistics, so system benches and on-chip self-test can measure the mesh in hardware rather than with behavioural tasks.

## Interface
- `MY_X`, 0: node X coordinate.
- `MY_Y`, 0: node Y coordinate.
- `MESH_SIZE_X`, 4: mesh width; power of two.
- `MESH_SIZE_Y`, 4: mesh height; power of two.
- `NUM_PACKETS`, 20: flits injected per run; range 1..65535.
- `HOTSPOT_X`, 0; `HOTSPOT_Y`, 0: hotspot destination.
- `LFSR_SEED`, 16'hACE1: must be non-zero.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: pulse; begins a run. Honoured in IDLE or DONE only.
- `pattern` in 2: 0 uniform random, 1 nearest neighbour, 2 hotspot, 3 transpose. Sampled on `start`.
- `inj_rate` in 5: injection probability is inj_rate/16. A value of 16 or more means always inject. Sampled on `start`.
- `req_data` out flit_t: flit toward the router local request port.
- `req_valid` out 1 / `req_ready` in 1: request handshake.
- `resp_data` in flit_t: flit from the router local response port.
- `resp_valid` in 1 / `resp_ready` out 1: response handshake.
- `busy` out 1: in GEN or SEND.
- `done` out 1: in DONE.
- `pkts_sent` out 16: request handshakes completed in this run.
- `pkts_recv` out 16: response handshakes completed in this run.
- `max_latency` out 16: largest observed latency.
- `lat_sum` out 32: sum of latencies; wraps on overflow.
- `err_misroute` out 1: sticky; set when a received flit's dest does not equal (MY_X, MY_Y).

## Operation
- **FSM states:** IDLE, GEN, SEND, DONE.
  - IDLE or DONE, `start`=1: go to GEN. Clear `pkts_sent`, `pkts_recv`, `max_latency`, `lat_sum`, `err_misroute`.
  - GEN: if `lfsr[3:0] < inj_rate`, build a flit and go to SEND. Otherwise stay in GEN.
  - SEND: hold `req_valid`. On `req_valid && req_ready`, increment `pkts_sent`. If the new count equals `NUM_PACKETS`, go to DONE; otherwise go to GEN.
  - `start` in GEN or SEND is ignored.
- **LFSR:** 16-bit Galois, taps 0xB400. Advances every cycle outside reset.
- **Destination by pattern:**
  - Uniform: `x = lfsr[7:4] mod MESH_SIZE_X`, `y = lfsr[11:8] mod MESH_SIZE_Y`. Self is allowed.
  - Nearest neighbour: `((MY_X+1) mod MESH_SIZE_X, MY_Y)`.
  - Hotspot: `(HOTSPOT_X, HOTSPOT_Y)`. If this node is the hotspot, use the uniform rule instead.
  - Transpose: `(MY_Y, MY_X)`. Requires a square mesh; diagonal nodes send to self.
- **Flit fields:**
  - `packet_type = PACKET_DATA`, `src = (MY_X, MY_Y)`, `sequence_num = pkts_sent`, `valid = 1`.
  - `data[15:0]` = `cyc` on the GEN→SEND cycle; upper data bits are 0.
- **Cycle counter:** `cyc` is a free-running 16-bit counter, reset to 0, incremented every cycle.
- **Sink:** independent of the FSM and always active after reset. On `resp_valid && resp_ready`:
  - `latency = cyc - resp_data.data[15:0]`, computed modulo 2^16.
  - `pkts_recv++`, `lat_sum += latency`, `max_latency = max(max_latency, latency)`.
  - All packet types are counted.
  - A `start` in the same cycle as a handshake wins: counters clear and that flit is dropped from the statistics.

## Timing
- **Reset values:** all outputs 0, including `resp_ready` and `req_data`. The FSM goes to IDLE and the LFSR loads `LFSR_SEED`.
- `resp_ready` is registered and reads 1 from the first cycle after `rst_n` rises.
- `start` is registered. `busy` rises the cycle after `start` is sampled.
- Minimum GEN→SEND→handshake→GEN loop is 2 cycles per flit, so peak rate is 0.5 flit/cycle.
- `req_data` and `req_valid` are registered. While `req_valid`=1 and `req_ready`=0, `req_data` stays stable.
- Reset mid-run aborts immediately. Any in-flight flit is dropped, with no handshake completion.
- `inj_rate`=0 stays in GEN indefinitely, and `done` never asserts.

## Structure
- Add `traffic_pattern_t` (2-bit enum), `NEBULA_LFSR_TAPS`, and `NEBULA_TS_W=16` to `nebula_pkg`.
- `flit_t` and `PACKET_DATA` come from `nebula_pkg`.
- One sub-module: `nebula_lfsr16` (seed param, `clk`, `rst_n`, 16-bit `q`).

## Test plan
- **Reset:** hold `rst_n`=0 for 5 cycles → all outputs 0. One cycle after release → `resp_ready`=1, `busy`=0.
- **Nearest neighbour:** node (1,2), `NUM_PACKETS`=4, `inj_rate`=16, `req_ready`=1 → four flits with dest (2,2), `sequence_num` 0..3, src (1,2). Then `done`=1 and `pkts_sent`=4.
- **Backpressure:** hold `req_ready`=0 for 10 cycles during SEND → `req_valid` stays 1, `req_data` is unchanged, `pkts_sent` is unchanged. Release `req_ready` → exactly one increment.
- **Latency:** drive a resp flit whose `data[15:0]` equals `cyc-7`, then another at `cyc-3` → `pkts_recv`=2, `max_latency`=7, `lat_sum`=10. Repeat with the timestamp at 0xFFFE and `cyc`=0x0002 → latency 4.
- **Misroute:** node (1,2) receives a flit with dest (3,3) → `err_misroute`=1 and stays 1 until the next `start`.
- **Transpose and hotspot:** transpose at (3,1) → dest (1,3). Hotspot at (2,2) with `HOTSPOT` (0,0) → every dest is (0,0). `inj_rate`=0 for 100 cycles → `pkts_sent`=0 and `done`=0.
